// File: rtl/hpi_responder.sv
// hpi_responder
//   Emulates the CY7C67200 Host Port Interface as seen from the HPI master.
//   It provides the address pointer, a 2^MEM_AW x 16-bit word memory, two
//   mailboxes and the STATUS register. The block stands in for the real USB
//   controller in loopback builds and in simulation.
//
//   Optional feature macro: HPI_RESP_MBX_INT_EN
//     defined   : hpi_int is a registered copy of mbx_out_full.
//     undefined : hpi_int is tied 0, and the host polls STATUS bit 0.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   hpi_addr[1:0]     register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS
//   hpi_cs_n/rd_n/wr_n/rst_n  asynchronous active-low HPI strobes
//   hpi_data_in[15:0] write data from the pad
//   hpi_data_out[15:0], hpi_data_oe  read data and pad driver enable
//   hpi_int           interrupt to the host, active-high
//   mbx_in_data/valid/ack   host-to-local mailbox
//   mbx_out_data/wr/full    local-to-host mailbox
module hpi_responder #(
  parameter int MEM_AW = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  hpi_addr,
  input  logic        hpi_cs_n,
  input  logic        hpi_rd_n,
  input  logic        hpi_wr_n,
  input  logic        hpi_rst_n,
  input  logic [15:0] hpi_data_in,
  output logic [15:0] hpi_data_out,
  output logic        hpi_data_oe,
  output logic        hpi_int,
  output logic [15:0] mbx_in_data,
  output logic        mbx_in_valid,
  input  logic        mbx_in_ack,
  input  logic [15:0] mbx_out_data,
  input  logic        mbx_out_wr,
  output logic        mbx_out_full
);

  localparam int DEPTH = 1 << MEM_AW;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_MBX  = 2'd1;
  localparam logic [1:0] REG_ADDR = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WRITE    = 2'd1,
    S_RD_FETCH = 2'd2,
    S_RD_DRIVE = 2'd3
  } state_t;

  // Two-flop synchronizers; the strobes come out of reset deasserted.
  logic [1:0] cs_sync_q, rd_sync_q, wr_sync_q, rst_sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync_q  <= 2'b11;
      rd_sync_q  <= 2'b11;
      wr_sync_q  <= 2'b11;
      rst_sync_q <= 2'b11;
    end else begin
      cs_sync_q  <= {cs_sync_q[0],  hpi_cs_n};
      rd_sync_q  <= {rd_sync_q[0],  hpi_rd_n};
      wr_sync_q  <= {wr_sync_q[0],  hpi_wr_n};
      rst_sync_q <= {rst_sync_q[0], hpi_rst_n};
    end
  end

  logic wr_act, rd_act, hrst_act, ctl_clear;
  assign wr_act    = ~cs_sync_q[1] & ~wr_sync_q[1];
  assign rd_act    = ~cs_sync_q[1] & ~rd_sync_q[1];
  assign hrst_act  = ~rst_sync_q[1];
  assign ctl_clear = reset | hrst_act;

  // Address and data are sampled throughout the strobe so the commit, which
  // happens after the synchronized strobe drops, uses the last stable value.
  logic [1:0]  addr_hold_q;
  logic [15:0] data_hold_q;

  always_ff @(posedge clk) begin
    if (wr_act) begin
      addr_hold_q <= hpi_addr;
      data_hold_q <= hpi_data_in;
    end
  end

  state_t      state_q;
  logic [15:0] ptr_q;
  logic [1:0]  rsel_q;
  logic [15:0] dout_q;
  logic        oe_q;
  logic [15:0] mbx_in_data_q;
  logic        mbx_in_valid_q;
  logic [15:0] mbx_out_data_q;
  logic        mbx_out_full_q;

  logic [15:0] mem [DEPTH];

  // Byte pointer to word index; bits above MEM_AW drop out, so the index
  // wraps modulo the memory depth.
  logic [MEM_AW-1:0] idx;
  assign idx = ptr_q[MEM_AW:1];

  logic commit, rd_done, mbx_wr_commit, mbx_rd_done, mem_we;
  assign commit        = (state_q == S_WRITE) && !wr_act && !ctl_clear;
  assign rd_done       = (state_q == S_RD_DRIVE) && !rd_act;
  assign mbx_wr_commit = commit && (addr_hold_q == REG_MBX);
  assign mbx_rd_done   = rd_done && (rsel_q == REG_MBX);
  assign mem_we        = commit && (addr_hold_q == REG_DATA);

  logic [15:0] rd_word;
  always_comb begin
    rd_word = 16'h0000;
    case (hpi_addr)
      REG_DATA: rd_word = mem[idx];
      REG_MBX:  rd_word = mbx_out_data_q;
      REG_ADDR: rd_word = ptr_q;
      REG_STAT: rd_word = {14'b0, mbx_in_valid_q, mbx_out_full_q};
      default:  rd_word = 16'h0000;
    endcase
  end

  // Memory contents survive both resets.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= data_hold_q;
    end
  end

  always_ff @(posedge clk) begin
    if (ctl_clear) begin
      state_q        <= S_IDLE;
      ptr_q          <= 16'h0000;
      rsel_q         <= REG_DATA;
      dout_q         <= 16'h0000;
      oe_q           <= 1'b0;
      mbx_in_data_q  <= 16'h0000;
      mbx_in_valid_q <= 1'b0;
      mbx_out_data_q <= 16'h0000;
      mbx_out_full_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A simultaneous read strobe is ignored in favour of the write.
          if (wr_act) begin
            state_q <= S_WRITE;
          end else if (rd_act) begin
            state_q <= S_RD_FETCH;
          end
        end
        S_WRITE: begin
          if (!wr_act) begin
            state_q <= S_IDLE;
            case (addr_hold_q)
              REG_DATA: ptr_q <= ptr_q + 16'd2;
              REG_ADDR: ptr_q <= data_hold_q;
              default:  ;
            endcase
          end
        end
        S_RD_FETCH: begin
          dout_q  <= rd_word;
          oe_q    <= 1'b1;
          rsel_q  <= hpi_addr;
          state_q <= S_RD_DRIVE;
        end
        S_RD_DRIVE: begin
          if (!rd_act) begin
            state_q <= S_IDLE;
            oe_q    <= 1'b0;
            if (rsel_q == REG_DATA) begin
              ptr_q <= ptr_q + 16'd2;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Host write beats a same-cycle local acknowledge.
      if (mbx_wr_commit) begin
        mbx_in_data_q  <= data_hold_q;
        mbx_in_valid_q <= 1'b1;
      end else if (mbx_in_ack) begin
        mbx_in_valid_q <= 1'b0;
      end

      // A post landing on the host's read completion sees the slot as free.
      if (mbx_out_wr && (!mbx_out_full_q || mbx_rd_done)) begin
        mbx_out_data_q <= mbx_out_data;
        mbx_out_full_q <= 1'b1;
      end else if (mbx_rd_done) begin
        mbx_out_full_q <= 1'b0;
      end
    end
  end

`ifdef HPI_RESP_MBX_INT_EN
  logic int_q;
  always_ff @(posedge clk) begin
    if (ctl_clear) begin
      int_q <= 1'b0;
    end else begin
      int_q <= mbx_out_full_q;
    end
  end
  assign hpi_int = int_q;
`else
  assign hpi_int = 1'b0;
`endif

  assign hpi_data_out = dout_q;
  assign hpi_data_oe  = oe_q;
  assign mbx_in_data  = mbx_in_data_q;
  assign mbx_in_valid = mbx_in_valid_q;
  assign mbx_out_full = mbx_out_full_q;

endmodule

// File: tb/tb_hpi_responder.sv
// Directed testbench for hpi_responder: host bus cycles are driven on the
// falling clock edge and outputs are sampled on the falling edge as well.
module tb_hpi_responder;

  logic        clk;
  logic        reset;
  logic [1:0]  hpi_addr;
  logic        hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_rst_n;
  logic [15:0] hpi_data_in;
  logic [15:0] hpi_data_out;
  logic        hpi_data_oe;
  logic        hpi_int;
  logic [15:0] mbx_in_data;
  logic        mbx_in_valid;
  logic        mbx_in_ack;
  logic [15:0] mbx_out_data;
  logic        mbx_out_wr;
  logic        mbx_out_full;

  int checks = 0;
  int errors = 0;

`ifdef HPI_RESP_MBX_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  hpi_responder #(.MEM_AW(10)) dut (
    .clk(clk), .reset(reset),
    .hpi_addr(hpi_addr), .hpi_cs_n(hpi_cs_n), .hpi_rd_n(hpi_rd_n),
    .hpi_wr_n(hpi_wr_n), .hpi_rst_n(hpi_rst_n), .hpi_data_in(hpi_data_in),
    .hpi_data_out(hpi_data_out), .hpi_data_oe(hpi_data_oe), .hpi_int(hpi_int),
    .mbx_in_data(mbx_in_data), .mbx_in_valid(mbx_in_valid), .mbx_in_ack(mbx_in_ack),
    .mbx_out_data(mbx_out_data), .mbx_out_wr(mbx_out_wr), .mbx_out_full(mbx_out_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    hpi_addr = a; hpi_data_in = d;
    hpi_cs_n = 1'b0; hpi_wr_n = 1'b0;
    cycles(8);
    hpi_cs_n = 1'b1; hpi_wr_n = 1'b1;
    cycles(6);
  endtask

  task automatic host_read(input logic [1:0] a, output logic [15:0] d, output logic oe);
    @(negedge clk);
    hpi_addr = a;
    hpi_cs_n = 1'b0; hpi_rd_n = 1'b0;
    cycles(8);
    d = hpi_data_out; oe = hpi_data_oe;
    hpi_cs_n = 1'b1; hpi_rd_n = 1'b1;
    cycles(6);
  endtask

  task automatic post(input logic [15:0] d);
    @(negedge clk);
    mbx_out_data = d; mbx_out_wr = 1'b1;
    @(negedge clk);
    mbx_out_wr = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    cycles(4);
    reset = 1'b0;
    cycles(1);
    checks++; if (hpi_data_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", hpi_data_oe); end
    checks++; if (hpi_data_out !== 16'h0000) begin errors++; $display("FAIL reset_dout got %h exp 0000", hpi_data_out); end
    checks++; if (hpi_int !== 1'b0) begin errors++; $display("FAIL reset_int got %b exp 0", hpi_int); end
    checks++; if (mbx_in_valid !== 1'b0) begin errors++; $display("FAIL reset_in_valid got %b exp 0", mbx_in_valid); end
    checks++; if (mbx_in_data !== 16'h0000) begin errors++; $display("FAIL reset_in_data got %h exp 0000", mbx_in_data); end
    checks++; if (mbx_out_full !== 1'b0) begin errors++; $display("FAIL reset_out_full got %b exp 0", mbx_out_full); end
  endtask

  task automatic test_data_rw;
    logic [15:0] d; logic oe;
    host_write(2'd2, 16'h0100);
    host_write(2'd0, 16'hA5A5);
    host_write(2'd0, 16'h5A5A);
    host_write(2'd2, 16'h0100);
    host_read(2'd0, d, oe);
    checks++; if (d !== 16'hA5A5) begin errors++; $display("FAIL data_rd0 got %h exp a5a5", d); end
    checks++; if (oe !== 1'b1) begin errors++; $display("FAIL data_rd0_oe got %b exp 1", oe); end
    host_read(2'd0, d, oe);
    checks++; if (d !== 16'h5A5A) begin errors++; $display("FAIL data_rd1 got %h exp 5a5a", d); end
    host_read(2'd2, d, oe);
    checks++; if (d !== 16'h0104) begin errors++; $display("FAIL ptr_after got %h exp 0104", d); end
  endtask

  task automatic test_wrap;
    logic [15:0] d; logic oe;
    host_write(2'd2, 16'h0800);
    host_write(2'd0, 16'h1234);
    host_write(2'd2, 16'h0000);
    host_read(2'd0, d, oe);
    checks++; if (d !== 16'h1234) begin errors++; $display("FAIL idx_wrap got %h exp 1234", d); end
    host_write(2'd2, 16'hFFFE);
    host_write(2'd0, 16'h7777);
    host_read(2'd2, d, oe);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL ptr_wrap got %h exp 0000", d); end
  endtask

  task automatic test_mbx_in;
    logic [15:0] d; logic oe;
    host_write(2'd1, 16'hBEEF);
    checks++; if (mbx_in_valid !== 1'b1) begin errors++; $display("FAIL mbx_in_valid got %b exp 1", mbx_in_valid); end
    checks++; if (mbx_in_data !== 16'hBEEF) begin errors++; $display("FAIL mbx_in_data got %h exp beef", mbx_in_data); end
    host_read(2'd3, d, oe);
    checks++; if (d !== 16'h0002) begin errors++; $display("FAIL status_in got %h exp 0002", d); end
    @(negedge clk); mbx_in_ack = 1'b1;
    @(negedge clk); mbx_in_ack = 1'b0;
    checks++; if (mbx_in_valid !== 1'b0) begin errors++; $display("FAIL mbx_in_ack got %b exp 0", mbx_in_valid); end
    host_read(2'd3, d, oe);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL status_clr got %h exp 0000", d); end
  endtask

  task automatic test_mbx_out;
    logic [15:0] d; logic oe;
    post(16'h1111);
    checks++; if (mbx_out_full !== 1'b1) begin errors++; $display("FAIL out_full_set got %b exp 1", mbx_out_full); end
    checks++; if (hpi_int !== 1'b0) begin errors++; $display("FAIL int_lag got %b exp 0", hpi_int); end
    @(negedge clk);
    checks++; if (hpi_int !== INT_EN) begin errors++; $display("FAIL int_rise got %b exp %b", hpi_int, INT_EN); end
    post(16'h2222);
    checks++; if (mbx_out_full !== 1'b1) begin errors++; $display("FAIL out_full_drop got %b exp 1", mbx_out_full); end
    // MAILBOX read with cycle-accurate oe and full/int timing
    @(negedge clk);
    hpi_addr = 2'd1; hpi_cs_n = 1'b0; hpi_rd_n = 1'b0;
    cycles(3);
    checks++; if (hpi_data_oe !== 1'b0) begin errors++; $display("FAIL oe_early got %b exp 0", hpi_data_oe); end
    cycles(1);
    checks++; if (hpi_data_oe !== 1'b1) begin errors++; $display("FAIL oe_rise got %b exp 1", hpi_data_oe); end
    checks++; if (hpi_data_out !== 16'h1111) begin errors++; $display("FAIL mbx_out_rd got %h exp 1111", hpi_data_out); end
    cycles(4);
    hpi_cs_n = 1'b1; hpi_rd_n = 1'b1;
    cycles(2);
    checks++; if (hpi_data_oe !== 1'b1 || mbx_out_full !== 1'b1) begin errors++; $display("FAIL rd_hold got oe %b full %b exp 1 1", hpi_data_oe, mbx_out_full); end
    cycles(1);
    checks++; if (hpi_data_oe !== 1'b0) begin errors++; $display("FAIL oe_fall got %b exp 0", hpi_data_oe); end
    checks++; if (mbx_out_full !== 1'b0) begin errors++; $display("FAIL out_full_clr got %b exp 0", mbx_out_full); end
    checks++; if (hpi_int !== INT_EN) begin errors++; $display("FAIL int_hold got %b exp %b", hpi_int, INT_EN); end
    cycles(1);
    checks++; if (hpi_int !== 1'b0) begin errors++; $display("FAIL int_fall got %b exp 0", hpi_int); end
    cycles(3);
    // Post landing on the same edge as the read completion
    post(16'h3333);
    @(negedge clk);
    hpi_addr = 2'd1; hpi_cs_n = 1'b0; hpi_rd_n = 1'b0;
    cycles(8);
    checks++; if (hpi_data_out !== 16'h3333) begin errors++; $display("FAIL mbx_rd3 got %h exp 3333", hpi_data_out); end
    hpi_cs_n = 1'b1; hpi_rd_n = 1'b1;
    cycles(2);
    mbx_out_data = 16'h4444; mbx_out_wr = 1'b1;
    cycles(1);
    mbx_out_wr = 1'b0;
    checks++; if (mbx_out_full !== 1'b1) begin errors++; $display("FAIL post_on_clear got %b exp 1", mbx_out_full); end
    cycles(4);
    host_read(2'd1, d, oe);
    checks++; if (d !== 16'h4444) begin errors++; $display("FAIL post_on_clear_data got %h exp 4444", d); end
  endtask

  task automatic test_hpi_rst;
    logic [15:0] d; logic oe;
    host_write(2'd2, 16'h0010);
    host_write(2'd0, 16'hCAFE);
    host_write(2'd1, 16'h5555);
    post(16'h6666);
    host_write(2'd2, 16'h0010);
    // DATA write abandoned by an hpi_rst_n pulse
    @(negedge clk);
    hpi_addr = 2'd0; hpi_data_in = 16'hDEAD;
    hpi_cs_n = 1'b0; hpi_wr_n = 1'b0;
    cycles(4);
    hpi_rst_n = 1'b0;
    cycles(2);
    hpi_cs_n = 1'b1; hpi_wr_n = 1'b1;
    cycles(6);
    hpi_rst_n = 1'b1;
    cycles(6);
    checks++; if (mbx_in_valid !== 1'b0 || mbx_in_data !== 16'h0000) begin errors++; $display("FAIL hrst_mbx_in got %b %h exp 0 0000", mbx_in_valid, mbx_in_data); end
    checks++; if (mbx_out_full !== 1'b0) begin errors++; $display("FAIL hrst_mbx_out got %b exp 0", mbx_out_full); end
    host_read(2'd2, d, oe);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL hrst_ptr got %h exp 0000", d); end
    host_write(2'd2, 16'h0010);
    host_read(2'd0, d, oe);
    checks++; if (d !== 16'hCAFE) begin errors++; $display("FAIL hrst_mem got %h exp cafe", d); end
  endtask

  task automatic test_rd_wr_collision;
    logic [15:0] d; logic oe;
    logic oe_seen;
    host_write(2'd2, 16'h0020);
    oe_seen = 1'b0;
    @(negedge clk);
    hpi_addr = 2'd0; hpi_data_in = 16'h0F0F;
    hpi_cs_n = 1'b0; hpi_wr_n = 1'b0; hpi_rd_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (hpi_data_oe !== 1'b0) oe_seen = 1'b1;
    end
    hpi_cs_n = 1'b1; hpi_wr_n = 1'b1; hpi_rd_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (hpi_data_oe !== 1'b0) oe_seen = 1'b1;
    end
    checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL collide_oe got %b exp 0", oe_seen); end
    host_read(2'd2, d, oe);
    checks++; if (d !== 16'h0022) begin errors++; $display("FAIL collide_ptr got %h exp 0022", d); end
    host_write(2'd2, 16'h0020);
    host_read(2'd0, d, oe);
    checks++; if (d !== 16'h0F0F) begin errors++; $display("FAIL collide_mem got %h exp 0f0f", d); end
  endtask

  initial begin
    reset = 1'b1;
    hpi_addr = 2'd0; hpi_data_in = 16'h0000;
    hpi_cs_n = 1'b1; hpi_rd_n = 1'b1; hpi_wr_n = 1'b1; hpi_rst_n = 1'b1;
    mbx_in_ack = 1'b0; mbx_out_data = 16'h0000; mbx_out_wr = 1'b0;
    test_reset;
    test_data_rw;
    test_wrap;
    test_mbx_in;
    test_mbx_out;
    test_hpi_rst;
    test_rd_wr_collision;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
